// File: rtl/image_patch_streamer_if.sv
// Host-side frame/control signals and classifier pixel port of image_patch_streamer.
// master: the streamer. slave: host plus classifier.
interface image_patch_streamer_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              go;
  logic              busy;
  logic              result_valid;
  logic [1:0]        result_class;
  logic              result_err;
  logic              cls_start;
  logic [7:0]        cls_pixel;
  logic              cls_pixel_valid;
  logic              cls_ready;
  logic              cls_done;
  logic [1:0]        cls_class;

  modport master (
    input  wr_en, wr_addr, wr_data, go, cls_ready, cls_done, cls_class,
    output busy, result_valid, result_class, result_err, cls_start, cls_pixel, cls_pixel_valid
  );

  modport slave (
    output wr_en, wr_addr, wr_data, go, cls_ready, cls_done, cls_class,
    input  busy, result_valid, result_class, result_err, cls_start, cls_pixel, cls_pixel_valid
  );
endinterface

// File: rtl/image_patch_streamer.sv
// Streams a buffered raster frame to the classifier in patch-major order and latches its result.
// Optional WAIT_DONE watchdog enabled by defining STREAMER_TIMEOUT_EN.
module image_patch_streamer #(
  parameter int unsigned IMAGE_SIZE = 28,
  parameter int unsigned PATCH_SIZE = IMAGE_SIZE / 4,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned TIMEOUT    = 1024
) (
  input logic                    clk,
  input logic                    rst,
  image_patch_streamer_if.master bus
);

  localparam int unsigned NumPix   = IMAGE_SIZE * IMAGE_SIZE;
  localparam int unsigned NumPatch = IMAGE_SIZE / PATCH_SIZE;
  localparam int unsigned CntW     = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StWaitReady,
    StStart,
    StStream,
    StWaitDone
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0] pr_q, pc_q, r_q, c_q;
  logic [CntW-1:0] pr_d, pc_d, r_d, c_d;

  logic              issue;
  logic              last_idx;
  logic              done_take;
  logic              tmo_take;
  logic              tmo_hit;
  logic [ADDR_W-1:0] rd_addr;

  logic [7:0] frame_mem [NumPix];
  logic [7:0] pixel_q;
  logic       pixel_valid_q;
  logic       result_valid_q;
  logic [1:0] result_class_q;

  assign last_idx = (pr_q == CntW'(NumPatch - 1)) && (pc_q == CntW'(NumPatch - 1)) &&
                    (r_q == CntW'(PATCH_SIZE - 1)) && (c_q == CntW'(PATCH_SIZE - 1));

  assign rd_addr = ADDR_W'((32'(pr_q) * PATCH_SIZE + 32'(r_q)) * IMAGE_SIZE +
                           32'(pc_q) * PATCH_SIZE + 32'(c_q));

  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    done_take = 1'b0;
    tmo_take  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.go) state_d = bus.cls_ready ? StStart : StWaitReady;
      end
      StWaitReady: begin
        if (bus.cls_ready) state_d = StStart;
      end
      StStart: begin
        issue   = 1'b1;
        state_d = StStream;
      end
      StStream: begin
        issue = 1'b1;
        if (last_idx) state_d = StWaitDone;
      end
      StWaitDone: begin
        // A done arriving on the expiry edge takes priority over the timeout.
        if (bus.cls_done) begin
          done_take = 1'b1;
          state_d   = StIdle;
        end else if (tmo_hit) begin
          tmo_take = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Scan counters, inner column carrying outward to patch row.
  always_comb begin
    pr_d = pr_q;
    pc_d = pc_q;
    r_d  = r_q;
    c_d  = c_q;
    if (state_q == StIdle) begin
      pr_d = '0;
      pc_d = '0;
      r_d  = '0;
      c_d  = '0;
    end else if (issue) begin
      if (c_q == CntW'(PATCH_SIZE - 1)) begin
        c_d = '0;
        if (r_q == CntW'(PATCH_SIZE - 1)) begin
          r_d = '0;
          if (pc_q == CntW'(NumPatch - 1)) begin
            pc_d = '0;
            pr_d = (pr_q == CntW'(NumPatch - 1)) ? '0 : pr_q + CntW'(1);
          end else begin
            pc_d = pc_q + CntW'(1);
          end
        end else begin
          r_d = r_q + CntW'(1);
        end
      end else begin
        c_d = c_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      pr_q           <= '0;
      pc_q           <= '0;
      r_q            <= '0;
      c_q            <= '0;
      pixel_q        <= '0;
      pixel_valid_q  <= 1'b0;
      result_valid_q <= 1'b0;
      result_class_q <= '0;
    end else begin
      state_q        <= state_d;
      pr_q           <= pr_d;
      pc_q           <= pc_d;
      r_q            <= r_d;
      c_q            <= c_d;
      pixel_valid_q  <= issue;
      pixel_q        <= issue ? frame_mem[rd_addr] : 8'h00;
      result_valid_q <= done_take | tmo_take;
      if (done_take) begin
        result_class_q <= bus.cls_class;
      end else if (tmo_take) begin
        result_class_q <= '0;
      end
    end
  end

  // Host writes land only while idle so a running stream never sees a torn frame.
  always_ff @(posedge clk) begin
    if (bus.wr_en && (state_q == StIdle) && (32'(bus.wr_addr) < NumPix)) begin
      frame_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

`ifdef STREAMER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  logic [TmoW-1:0] tmo_q;
  logic            result_err_q;

  always_ff @(posedge clk) begin
    if (rst || (state_q != StWaitDone)) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TmoW'(1);
    end
  end

  assign tmo_hit = (state_q == StWaitDone) && (tmo_q == TmoW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      result_err_q <= 1'b0;
    end else if (done_take) begin
      result_err_q <= 1'b0;
    end else if (tmo_take) begin
      result_err_q <= 1'b1;
    end
  end

  assign bus.result_err = result_err_q;
`else
  assign tmo_hit        = 1'b0;
  assign bus.result_err = 1'b0;
`endif

  assign bus.busy            = (state_q != StIdle);
  assign bus.cls_start       = (state_q == StStart);
  assign bus.cls_pixel       = pixel_q;
  assign bus.cls_pixel_valid = pixel_valid_q;
  assign bus.result_valid    = result_valid_q;
  assign bus.result_class    = result_class_q;

endmodule

// File: tb/tb_image_patch_streamer.sv
// Directed self-checking bench for image_patch_streamer (28x28 frame, 7x7 patches).
module tb_image_patch_streamer;

`ifdef STREAMER_TIMEOUT_EN
  localparam int unsigned TbTimeout = 16;
`else
  localparam int unsigned TbTimeout = 1024;
`endif
  localparam int NPix = 784;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  image_patch_streamer_if #(.ADDR_W(10)) bus ();

  image_patch_streamer #(
    .IMAGE_SIZE(28),
    .PATCH_SIZE(7),
    .ADDR_W    (10),
    .TIMEOUT   (TbTimeout)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive monitor sampled on the falling edge.
  int         cyc = 0;
  int         start_cnt = 0;
  int         start_cyc = 0;
  int         pix_cnt = 0;
  int         first_valid_cyc = 0;
  int         last_valid_cyc = 0;
  int         rv_cnt = 0;
  int         rv_cyc = 0;
  int         idle_nz = 0;
  logic [7:0] pix_buf [1024];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.cls_start === 1'b1) begin
      start_cnt = start_cnt + 1;
      start_cyc = cyc;
      pix_cnt   = 0;
    end
    if (bus.cls_pixel_valid === 1'b1) begin
      if (pix_cnt < 1024) pix_buf[pix_cnt] = bus.cls_pixel;
      if (pix_cnt == 0) first_valid_cyc = cyc;
      last_valid_cyc = cyc;
      pix_cnt = pix_cnt + 1;
    end else if (bus.cls_pixel !== 8'h00) begin
      idle_nz = idle_nz + 1;
    end
    if (bus.result_valid === 1'b1) begin
      rv_cnt = rv_cnt + 1;
      rv_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame();
    for (int a = 0; a < NPix; a++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 10'(a);
      bus.wr_data = 8'(a);
      tick();
    end
    bus.wr_en = 1'b0;
  endtask

  // Called in the cls_start cycle; returns in the cycle after the last valid pixel.
  task automatic wait_stream();
    tick();
    for (int i = 0; i < 2000 && pix_cnt < NPix; i++) tick();
    checks++;
    if (pix_cnt < NPix) begin
      errors++;
      $display("FAIL wait_stream: got %0d pixels, need %0d", pix_cnt, NPix);
    end
  endtask

  // Returns in the cycle after the edge that samples cls_done.
  task automatic pulse_done(input int gap, input logic [1:0] cls);
    for (int i = 0; i < gap - 1; i++) tick();
    bus.cls_done  = 1'b1;
    bus.cls_class = cls;
    tick();
    bus.cls_done  = 1'b0;
    bus.cls_class = 2'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL rst_rv: got %b want 0", bus.result_valid); end
    checks++; if (bus.result_class !== 2'd0) begin errors++; $display("FAIL rst_class: got %0d want 0", bus.result_class); end
    checks++; if (bus.result_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bus.result_err); end
    checks++; if (bus.cls_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b want 0", bus.cls_start); end
    checks++; if (bus.cls_pixel !== 8'h00) begin errors++; $display("FAIL rst_pixel: got %h want 00", bus.cls_pixel); end
    checks++; if (bus.cls_pixel_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.cls_pixel_valid); end
  endtask

  task automatic test_stream();
    int exp_idx [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 49, 196, 783};
    int exp_val [11] = '{0, 1, 2, 3, 4, 5, 6, 28, 7, 196, 15};
    int s0, r0, bad;
    s0 = start_cnt;
    r0 = rv_cnt;
    bus.cls_ready = 1'b1;
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL go_busy: got %b want 1", bus.busy); end
    checks++; if (bus.cls_start !== 1'b1) begin errors++; $display("FAIL go_start: got %b want 1", bus.cls_start); end
    wait_stream();
    checks++;
    if (first_valid_cyc - start_cyc != 1) begin
      errors++; $display("FAIL first_valid_lat: got %0d want 1", first_valid_cyc - start_cyc);
    end
    checks++;
    if (last_valid_cyc - first_valid_cyc != NPix - 1) begin
      errors++; $display("FAIL contiguous: span %0d want %0d", last_valid_cyc - first_valid_cyc, NPix - 1);
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (pix_buf[exp_idx[i]] !== 8'(exp_val[i])) begin
        errors++;
        $display("FAIL pixel_%0d: got %0d want %0d", exp_idx[i], pix_buf[exp_idx[i]], exp_val[i]);
      end
    end
    bad = 0;
    for (int i = 0; i < NPix; i++) begin
      int pr, pc, r, c, addr;
      pr   = i / 196;
      pc   = (i % 196) / 49;
      r    = (i % 49) / 7;
      c    = i % 7;
      addr = (pr * 7 + r) * 28 + pc * 7 + c;
      if (pix_buf[i] !== 8'(addr)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL scan_order: %0d wrong pixels, want 0", bad); end
    pulse_done(20, 2'd2);
    checks++; if (bus.result_valid !== 1'b1) begin errors++; $display("FAIL res_valid: got %b want 1", bus.result_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL res_busy: got %b want 0", bus.busy); end
    checks++; if (bus.result_class !== 2'd2) begin errors++; $display("FAIL res_class: got %0d want 2", bus.result_class); end
    checks++; if (bus.result_err !== 1'b0) begin errors++; $display("FAIL res_err: got %b want 0", bus.result_err); end
    tick();
    checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL res_pulse: got %b want 0", bus.result_valid); end
    checks++; if (bus.result_class !== 2'd2) begin errors++; $display("FAIL res_hold: got %0d want 2", bus.result_class); end
    tick();
    checks++; if (start_cnt - s0 != 1) begin errors++; $display("FAIL start_once: got %0d want 1", start_cnt - s0); end
    checks++; if (rv_cnt - r0 != 1) begin errors++; $display("FAIL rv_once: got %0d want 1", rv_cnt - r0); end
    checks++; if (pix_cnt != NPix) begin errors++; $display("FAIL pix_total: got %0d want %0d", pix_cnt, NPix); end
  endtask

  task automatic test_wait_ready();
    int s0, bad;
    s0 = start_cnt;
    bus.cls_ready = 1'b0;
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b want 1", bus.busy); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.cls_start !== 1'b0 || bus.cls_pixel_valid !== 1'b0) bad++;
      if (i == 1) bus.go = 1'b1;
      tick();
      bus.go = 1'b0;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL wr_early: %0d early cycles, want 0", bad); end
    bus.cls_ready = 1'b1;
    tick();
    checks++; if (bus.cls_start !== 1'b1) begin errors++; $display("FAIL wr_start: got %b want 1", bus.cls_start); end
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    for (int i = 0; i < 2000 && pix_cnt < NPix; i++) tick();
    checks++; if (pix_cnt != NPix) begin errors++; $display("FAIL wr_pixels: got %0d want %0d", pix_cnt, NPix); end
    pulse_done(20, 2'd3);
    checks++; if (bus.result_class !== 2'd3) begin errors++; $display("FAIL wr_class: got %0d want 3", bus.result_class); end
    for (int i = 0; i < 10; i++) tick();
    checks++; if (start_cnt - s0 != 1) begin errors++; $display("FAIL wr_go_ignored: starts %0d want 1", start_cnt - s0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL wr_idle: got %b want 0", bus.busy); end
  endtask

  task automatic test_write_during_stream();
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    bus.wr_en   = 1'b1;
    bus.wr_addr = 10'd0;
    bus.wr_data = 8'hFF;
    tick();
    bus.wr_en = 1'b0;
    for (int i = 0; i < 2000 && pix_cnt < NPix; i++) tick();
    pulse_done(3, 2'd1);
    checks++; if (pix_buf[0] !== 8'h00) begin errors++; $display("FAIL wds_first: got %h want 00", pix_buf[0]); end
    tick();
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    wait_stream();
    pulse_done(3, 2'd1);
    checks++; if (pix_buf[0] !== 8'h00) begin errors++; $display("FAIL wds_second: got %h want 00", pix_buf[0]); end
    checks++; if (pix_buf[8] !== 8'd29) begin errors++; $display("FAIL wds_pix8: got %0d want 29", pix_buf[8]); end
  endtask

  task automatic test_back_to_back();
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    wait_stream();
    pulse_done(4, 2'd1);
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    checks++; if (bus.cls_start !== 1'b1) begin errors++; $display("FAIL b2b_start: got %b want 1", bus.cls_start); end
    wait_stream();
    pulse_done(4, 2'd2);
    checks++; if (bus.result_valid !== 1'b1 || bus.result_class !== 2'd2) begin
      errors++; $display("FAIL b2b_result: valid %b class %0d want 1/2", bus.result_valid, bus.result_class);
    end
    tick();
  endtask

  task automatic test_reset_mid_stream();
    int r0;
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    tick();
    for (int i = 0; i < 2000 && pix_cnt < 300; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.cls_pixel_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", bus.cls_pixel_valid); end
    checks++; if (bus.cls_pixel !== 8'h00) begin errors++; $display("FAIL mid_pixel: got %h want 00", bus.cls_pixel); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
    checks++; if (bus.result_class !== 2'd0) begin errors++; $display("FAIL mid_class: got %0d want 0", bus.result_class); end
    checks++; if (bus.cls_start !== 1'b0 || bus.result_valid !== 1'b0 || bus.result_err !== 1'b0) begin
      errors++; $display("FAIL mid_ctrl: start %b rv %b err %b want 0", bus.cls_start, bus.result_valid, bus.result_err);
    end
    r0 = rv_cnt;
    for (int i = 0; i < 50; i++) tick();
    checks++; if (rv_cnt != r0) begin errors++; $display("FAIL mid_no_result: got %0d want 0", rv_cnt - r0); end
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    wait_stream();
    checks++; if (pix_buf[783] !== 8'd15) begin errors++; $display("FAIL mid_last: got %0d want 15", pix_buf[783]); end
    pulse_done(5, 2'd1);
    checks++; if (bus.result_class !== 2'd1) begin errors++; $display("FAIL mid_class2: got %0d want 1", bus.result_class); end
    tick();
  endtask

`ifdef STREAMER_TIMEOUT_EN
  task automatic test_timeout();
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    wait_stream();
    for (int i = 0; i < 100 && bus.result_valid !== 1'b1; i++) tick();
    checks++; if (bus.result_valid !== 1'b1) begin errors++; $display("FAIL tmo_valid: got %b want 1", bus.result_valid); end
    checks++; if (bus.result_err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b want 1", bus.result_err); end
    checks++; if (bus.result_class !== 2'd0) begin errors++; $display("FAIL tmo_class: got %0d want 0", bus.result_class); end
    tick();
    checks++; if (rv_cyc - last_valid_cyc != TbTimeout) begin
      errors++; $display("FAIL tmo_time: got %0d want %0d", rv_cyc - last_valid_cyc, TbTimeout);
    end
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    wait_stream();
    pulse_done(TbTimeout - 1, 2'd1);
    checks++; if (bus.result_valid !== 1'b1 || bus.result_err !== 1'b0) begin
      errors++; $display("FAIL tmo_race: valid %b err %b want 1/0", bus.result_valid, bus.result_err);
    end
    checks++; if (bus.result_class !== 2'd1) begin errors++; $display("FAIL tmo_race_class: got %0d want 1", bus.result_class); end
    tick();
  endtask
`endif

  initial begin
    rst           = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.go        = 1'b0;
    bus.cls_ready = 1'b1;
    bus.cls_done  = 1'b0;
    bus.cls_class = 2'd0;
    test_reset();
    load_frame();
    test_stream();
    test_wait_ready();
    test_write_during_stream();
    test_back_to_back();
    test_reset_mid_stream();
`ifdef STREAMER_TIMEOUT_EN
    test_timeout();
`endif
    checks++; if (idle_nz != 0) begin errors++; $display("FAIL idle_pixel_zero: %0d nonzero cycles, want 0", idle_nz); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_patch_streamer.md
# image_patch_streamer

Feeds a stored 8-bit image into `transformer_classifier` in the patch-major pixel order that block expects, then collects its class result. Host writes a raster-order frame into an internal buffer and pulses `go`. The block handshakes `start`/`ready`, streams `IMAGE_SIZE*IMAGE_SIZE` pixels back-to-back, waits for `done` and latches `class_out`. It sits between the host/DMA side and the classifier's pixel input port.

## Interface
- `IMAGE_SIZE`, 28, image edge in pixels; must be a multiple of `PATCH_SIZE`.
- `PATCH_SIZE`, `IMAGE_SIZE/4`, patch edge in pixels; must match the classifier instance.
- `ADDR_W`, 10, frame-buffer address width; `2**ADDR_W >= IMAGE_SIZE*IMAGE_SIZE`.
- `TIMEOUT`, 1024, cycles allowed in WAIT_DONE (used only with `STREAMER_TIMEOUT_EN`).
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  host frame-buffer write strobe.
- `wr_addr`  in  ADDR_W  raster address, `row*IMAGE_SIZE+col`.
- `wr_data`  in  8  pixel value.
- `go`  in  1  start one inference; sampled only in IDLE.
- `busy`  out  1  high from the cycle after accepted `go` until return to IDLE.
- `result_valid`  out  1  one-cycle pulse when a result or timeout is latched.
- `result_class`  out  2  latched class; held until next `result_valid`.
- `result_err`  out  1  latched timeout flag; held until next `result_valid`.
- `cls_start`  out  1  one-cycle start pulse to classifier.
- `cls_pixel`  out  8  pixel to classifier.
- `cls_pixel_valid`  out  1  pixel qualifier.
- `cls_ready`  in  1  classifier idle.
- `cls_done`  in  1  classifier result pulse.
- `cls_class`  in  2  classifier result, valid with `cls_done`.

## Operation
- Frame buffer: `IMAGE_SIZE*IMAGE_SIZE` x 8, one write port, one synchronous read port (1-cycle read latency). Writes with `wr_en` accepted only when `busy=0`; ignored otherwise. Addresses beyond the frame are ignored.
- Scan order: nested counters, outer to inner: patch row `pr`, patch col `pc`, inner row `r`, inner col `c`, each in `0..P-1` (`pr`,`pc` in `0..IMAGE_SIZE/P-1`). Read address = `(pr*P + r)*IMAGE_SIZE + pc*P + c`. Each inner counter wraps to 0 and carries into the next.
- FSM:
  - IDLE: on `go`, go to START if `cls_ready=1`, else WAIT_READY.
  - WAIT_READY: hold until `cls_ready=1`, then go to START.
  - START: `cls_start=1`; issue read of scan index 0; go to STREAM.
  - STREAM: issue one read per cycle; after the last index (`N-1`, `N=IMAGE_SIZE^2`) has been issued, go to WAIT_DONE.
  - WAIT_DONE: on `cls_done`, latch `cls_class` into `result_class`, clear `result_err`, pulse `result_valid`, go to IDLE.
- `cls_pixel_valid` is the read-issue flag delayed one cycle. `cls_pixel` is the buffer read data. `cls_pixel=0` whenever valid is low.
- Exactly `N` valid pixels per inference, contiguous with no bubbles, each patch's `P*P` pixels consecutive.
- `go` while `busy=1` is ignored. `cls_done` outside WAIT_DONE is ignored.

## Timing
- Reset values: `busy=0`, `result_valid=0`, `result_class=0`, `result_err=0`, `cls_start=0`, `cls_pixel=0`, `cls_pixel_valid=0`. FSM returns to IDLE and counters clear.
- `go` accepted at edge k with `cls_ready=1`: `busy`=1 and `cls_start`=1 in cycle k+1. `cls_pixel_valid`=1 for cycles k+2 through k+1+N.
- With `cls_ready=0`, `cls_start` asserts in the cycle after the first edge that samples `cls_ready=1`.
- `result_valid` asserts in the cycle after the edge that samples `cls_done`. `busy` falls in that same cycle.
- Back-to-back: `go` may be accepted in the `result_valid` cycle.
- Reset mid-stream: `cls_pixel_valid` is 0 in the cycle after the reset edge. The partial frame is abandoned and no `result_valid` is produced.

## Configuration
- `STREAMER_TIMEOUT_EN` defined:
  - A counter runs in WAIT_DONE.
  - If `cls_done` has not arrived after `TIMEOUT` cycles: `result_err=1`, `result_class=0`, `result_valid` pulses, FSM returns to IDLE.
  - A `cls_done` on the same edge as expiry wins, with `result_err=0`.
- Not defined: no counter is built, WAIT_DONE waits indefinitely, and `result_err` is tied to 0.

## Test plan
- Defaults. Write `pix[a]=a[7:0]`, `go` with `cls_ready=1`:
  - `cls_start` pulses once, then 784 contiguous valid pixels.
  - Pixel indices 0..7 carry values 0,1,2,3,4,5,6,28.
  - Index 49 = 7 (patch 1).
  - Index 196 = 196 (patch 4, address 196).
  - Index 783 = 783[7:0] = 15.
- Classifier model returns `cls_done` with `cls_class=2` 20 cycles after the last pixel:
  - `result_valid` pulses once, `result_class=2`, `result_err=0`.
  - `busy` falls in the same cycle as `result_valid`.
- Hold `cls_ready=0` for 5 cycles after `go`:
  - `cls_start` is delayed accordingly.
  - No pixels are driven before `cls_start`.
  - A second `go` during `busy` is ignored.
- Assert `wr_en` to address 0 with data 0xFF during STREAM, then run a second inference:
  - Both streams show pixel 0 = 0x00.
- Assert `rst` at valid pixel 300:
  - Next cycle `cls_pixel_valid=0` and all outputs are at reset values.
  - A fresh `go` streams a full 784 pixels.
- `STREAMER_TIMEOUT_EN`, `TIMEOUT=16`, no `cls_done`:
  - `result_valid` pulses with `result_err=1`, `result_class=0`.
- `STREAMER_TIMEOUT_EN`, `TIMEOUT=16`, `cls_done` arriving on the expiry edge:
  - `result_err=0`.
